// File: rtl/aud_ctrl_multislot_if.sv
// Bus bundle between the audio transport controller and its neighbours
// (keys, codec init, recorder, DSP/player, SRAM, status).
//   master : controller side (drives o_*, samples i_*)
//   slave  : environment side (drives i_*, samples o_*)
// Signal names carry the controller's point of view.
interface aud_ctrl_multislot_if #(
  parameter int ADDR_W  = 20,
  parameter int N_SLOTS = 4
);
  localparam int SEL_W   = $clog2(N_SLOTS);
  localparam int SLOT_AW = ADDR_W - SEL_W;

  // keys / mode
  logic               i_key_rec;
  logic               i_key_play;
  logic               i_key_stop;
  logic [SEL_W-1:0]   i_slot_sel;
  logic               i_loop;
  // codec init
  logic               o_i2c_start;
  logic               i_i2c_fin;
  // recorder
  logic               o_rec_start;
  logic               o_rec_pause;
  logic               o_rec_stop;
  logic               i_rec_wr;
  // DSP / player
  logic               o_dsp_start;
  logic               o_dsp_pause;
  logic               o_dsp_stop;
  logic               o_play_en;
  logic [SLOT_AW:0]   i_play_off;
  // SRAM
  logic [ADDR_W-1:0]  o_sram_addr;
  logic               o_sram_we_n;
  // status
  logic [2:0]         o_state;
  logic [SEL_W-1:0]   o_slot;
  logic [SLOT_AW:0]   o_len;
  logic               o_err;

  modport master (
    input  i_key_rec, i_key_play, i_key_stop, i_slot_sel, i_loop,
           i_i2c_fin, i_rec_wr, i_play_off,
    output o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop,
           o_dsp_start, o_dsp_pause, o_dsp_stop, o_play_en,
           o_sram_addr, o_sram_we_n, o_state, o_slot, o_len, o_err
  );

  modport slave (
    output i_key_rec, i_key_play, i_key_stop, i_slot_sel, i_loop,
           i_i2c_fin, i_rec_wr, i_play_off,
    input  o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop,
           o_dsp_start, o_dsp_pause, o_dsp_stop, o_play_en,
           o_sram_addr, o_sram_we_n, o_state, o_slot, o_len, o_err
  );
endinterface

// File: rtl/aud_ctrl_multislot.sv
// Audio transport controller for the WM8731 recorder/player path.
// Sequences codec init, turns key edges into one-cycle recorder/DSP
// commands, generates SRAM addresses for N_SLOTS equal slots and keeps the
// recorded length of every slot. Playback stops or loops at end of take.
// Ports:
//   i_AUD_BCLK : clock (codec bit clock)
//   i_rst_n    : asynchronous reset, active HIGH (legacy name)
//   bus        : aud_ctrl_multislot_if.master -- keys, codec init, recorder,
//                DSP, SRAM and status signals
module aud_ctrl_multislot #(
  parameter int ADDR_W  = 20,
  parameter int N_SLOTS = 4
) (
  input  logic                   i_AUD_BCLK,
  input  logic                   i_rst_n,
  aud_ctrl_multislot_if.master   bus
);
  localparam int SEL_W   = $clog2(N_SLOTS);
  localparam int SLOT_AW = ADDR_W - SEL_W;
  localparam int LEN_W   = SLOT_AW + 1;
  localparam logic [LEN_W-1:0] LAST = {1'b0, {SLOT_AW{1'b1}}};

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_I2C        = 3'd1,
    S_IDLE       = 3'd2,
    S_RECD       = 3'd3,
    S_RECD_PAUSE = 3'd4,
    S_PLAY       = 3'd5,
    S_PLAY_PAUSE = 3'd6
  } state_e;

  typedef struct packed {
    logic i2c_start;
    logic rec_start;
    logic rec_pause;
    logic rec_stop;
    logic dsp_start;
    logic dsp_pause;
    logic dsp_stop;
    logic err;
  } cmd_t;

  state_e                          state_q, state_d;
  cmd_t                            cmd_q, cmd_d;
  logic [2:0]                      key_d_q;      // {stop, play, rec}
  logic [SEL_W-1:0]                slot_q, slot_d;
  logic [LEN_W-1:0]                wr_cnt_q, wr_cnt_d;
  logic [N_SLOTS-1:0][LEN_W-1:0]   len_q, len_d;
  logic                            play_en_q, play_en_d;
  logic                            we_n_q;

  logic [2:0]       keys, edges;
  logic             stop_e, rec_e, play_e;
  logic             full, eot;
  logic [LEN_W-1:0] cur_len;

  assign keys  = {bus.i_key_stop, bus.i_key_play, bus.i_key_rec};
  assign edges = keys & ~key_d_q;

  // Only the highest-priority edge of a cycle acts: stop > rec > play.
  assign stop_e = edges[2];
  assign rec_e  = edges[0] & ~edges[2];
  assign play_e = edges[1] & ~edges[2] & ~edges[0];

  assign cur_len = len_q[slot_q];
  // Same-cycle compares; the reaction lands one cycle later via the flops.
  assign full    = bus.i_rec_wr && (wr_cnt_q == LAST);
  assign eot     = bus.i_play_off >= cur_len;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    wr_cnt_d  = wr_cnt_q;
    len_d     = len_q;
    play_en_d = play_en_q;
    cmd_d     = '0;
    case (state_q)
      S_INIT: begin
        cmd_d.i2c_start = 1'b1;
        state_d         = S_I2C;
      end
      S_I2C: begin
        if (bus.i_i2c_fin) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (rec_e) begin
          slot_d                 = bus.i_slot_sel;
          len_d[bus.i_slot_sel]  = '0;
          wr_cnt_d               = '0;
          cmd_d.rec_start        = 1'b1;
          state_d                = S_RECD;
        end else if (play_e) begin
          slot_d = bus.i_slot_sel;
          if (len_q[bus.i_slot_sel] == '0) begin
            cmd_d.err = 1'b1;
          end else begin
            cmd_d.dsp_start = 1'b1;
            play_en_d       = 1'b1;
            state_d         = S_PLAY;
          end
        end
      end
      S_RECD: begin
        if (bus.i_rec_wr) wr_cnt_d = wr_cnt_q + LEN_W'(1);
        // Stored length includes a write landing in the stopping cycle.
        if (stop_e || full) begin
          cmd_d.rec_stop = 1'b1;
          len_d[slot_q]  = wr_cnt_d;
          state_d        = S_IDLE;
        end else if (rec_e) begin
          cmd_d.rec_pause = 1'b1;
          state_d         = S_RECD_PAUSE;
        end else if (play_e) begin
          cmd_d.err = 1'b1;
        end
      end
      S_RECD_PAUSE: begin
        if (stop_e) begin
          cmd_d.rec_stop = 1'b1;
          len_d[slot_q]  = wr_cnt_q;
          state_d        = S_IDLE;
        end else if (rec_e) begin
          cmd_d.rec_start = 1'b1;
          state_d         = S_RECD;
        end else if (play_e) begin
          cmd_d.err = 1'b1;
        end
      end
      S_PLAY: begin
        if (stop_e || (eot && !bus.i_loop)) begin
          cmd_d.dsp_stop = 1'b1;
          play_en_d      = 1'b0;
          state_d        = S_IDLE;
        end else if (eot) begin
          // loop: restart the DSP in place, player stays enabled
          cmd_d.dsp_stop  = 1'b1;
          cmd_d.dsp_start = 1'b1;
        end else if (rec_e) begin
          cmd_d.err = 1'b1;
        end else if (play_e) begin
          cmd_d.dsp_pause = 1'b1;
          play_en_d       = 1'b0;
          state_d         = S_PLAY_PAUSE;
        end
      end
      S_PLAY_PAUSE: begin
        if (stop_e) begin
          cmd_d.dsp_stop = 1'b1;
          play_en_d      = 1'b0;
          state_d        = S_IDLE;
        end else if (rec_e) begin
          cmd_d.err = 1'b1;
        end else if (play_e) begin
          cmd_d.dsp_start = 1'b1;
          play_en_d       = 1'b1;
          state_d         = S_PLAY;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge i_AUD_BCLK or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_q   <= S_INIT;
      cmd_q     <= '0;
      key_d_q   <= '0;
      slot_q    <= '0;
      wr_cnt_q  <= '0;
      len_q     <= '0;
      play_en_q <= 1'b0;
      we_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      key_d_q   <= keys;
      slot_q    <= slot_d;
      wr_cnt_q  <= wr_cnt_d;
      len_q     <= len_d;
      play_en_q <= play_en_d;
      we_n_q    <= (state_d != S_RECD);
    end
  end

  // Record side addresses come straight from flops. In play the DSP owns
  // the offset, so its current value is used as-is under the latched slot
  // (no registering, which would hand it the previous offset's data).
  always_comb begin
    if (state_q == S_RECD || state_q == S_RECD_PAUSE)
      bus.o_sram_addr = {slot_q, wr_cnt_q[SLOT_AW-1:0]};
    else
      bus.o_sram_addr = {slot_q, bus.i_play_off[SLOT_AW-1:0]};
  end

  assign bus.o_i2c_start = cmd_q.i2c_start;
  assign bus.o_rec_start = cmd_q.rec_start;
  assign bus.o_rec_pause = cmd_q.rec_pause;
  assign bus.o_rec_stop  = cmd_q.rec_stop;
  assign bus.o_dsp_start = cmd_q.dsp_start;
  assign bus.o_dsp_pause = cmd_q.dsp_pause;
  assign bus.o_dsp_stop  = cmd_q.dsp_stop;
  assign bus.o_err       = cmd_q.err;
  assign bus.o_play_en   = play_en_q;
  assign bus.o_sram_we_n = we_n_q;
  assign bus.o_state     = state_q;
  assign bus.o_slot      = slot_q;
  assign bus.o_len       = cur_len;
endmodule

// File: tb/tb_aud_ctrl_multislot.sv
// Directed/randomised bench for aud_ctrl_multislot. 4 slots of 256 words
// (ADDR_W=10). Expected lengths and addresses come from a slot model:
// exp_len[] per slot, address = slot*256 + words-written / play offset.
module tb_aud_ctrl_multislot;
  localparam int ADDR_W  = 10;
  localparam int N_SLOTS = 4;
  localparam int SLOT_SZ = 256;

  localparam int ST_INIT = 0, ST_I2C = 1, ST_IDLE = 2, ST_RECD = 3,
                 ST_RECP = 4, ST_PLAY = 5, ST_PLAYP = 6;

  // pulse vector order: {i2c, rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop, err}
  localparam int P_I2C = 'h80, P_RS = 'h40, P_RP = 'h20, P_RSTOP = 'h10,
                 P_DS = 'h08, P_DP = 'h04, P_DSTOP = 'h02, P_ERR = 'h01;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   exp_len [N_SLOTS];

  aud_ctrl_multislot_if #(.ADDR_W(ADDR_W), .N_SLOTS(N_SLOTS)) bus ();
  aud_ctrl_multislot #(.ADDR_W(ADDR_W), .N_SLOTS(N_SLOTS)) dut (
    .i_AUD_BCLK (clk),
    .i_rst_n    (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pulses();
    return 32'({bus.o_i2c_start, bus.o_rec_start, bus.o_rec_pause, bus.o_rec_stop,
                bus.o_dsp_start, bus.o_dsp_pause, bus.o_dsp_stop, bus.o_err});
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_rec(input int slot);
    bus.i_slot_sel = 2'(slot);
    bus.i_key_rec  = 1'b1;
    cyc();
    chk("rec_start_pulse", pulses(), P_RS);
    chk("rec_start_state", 32'(bus.o_state), ST_RECD);
    chk("rec_we_n", 32'(bus.o_sram_we_n), 0);
    bus.i_key_rec = 1'b0;
  endtask

  // random write pattern until n reaches target; n carries words written
  task automatic rec_words(input int slot, input int target, inout int n);
    int guard = 0;
    while (n < target && guard < 4000) begin
      chk("rec_addr", 32'(bus.o_sram_addr), slot * SLOT_SZ + n);
      bus.i_rec_wr = ($urandom_range(0, 3) != 0);
      cyc();
      guard++;
      if (bus.i_rec_wr) n++;
      chk("rec_state", 32'(bus.o_state), ST_RECD);
      chk("rec_no_pulse", pulses(), 0);
    end
    bus.i_rec_wr = 1'b0;
  endtask

  task automatic stop_rec(input int slot);
    bus.i_key_stop = 1'b1;
    cyc();
    chk("rec_stop_pulse", pulses(), P_RSTOP);
    chk("rec_stop_state", 32'(bus.o_state), ST_IDLE);
    chk("rec_stop_len", 32'(bus.o_len), exp_len[slot]);
    chk("rec_stop_we_n", 32'(bus.o_sram_we_n), 1);
    bus.i_key_stop = 1'b0;
    cyc();
    chk("rec_stop_once", pulses(), 0);
  endtask

  task automatic start_play(input int slot);
    bus.i_slot_sel = 2'(slot);
    bus.i_play_off = '0;
    bus.i_key_play = 1'b1;
    cyc();
    chk("play_start_pulse", pulses(), P_DS);
    chk("play_start_state", 32'(bus.o_state), ST_PLAY);
    chk("play_en_on", 32'(bus.o_play_en), 1);
    bus.i_key_play = 1'b0;
  endtask

  task automatic boot();
    rst_n = 1'b0;
    cyc();
    chk("boot_i2c_pulse", pulses(), P_I2C);
    chk("boot_state_i2c", 32'(bus.o_state), ST_I2C);
    cyc();
    chk("boot_state_idle", 32'(bus.o_state), ST_IDLE);
    for (int s = 0; s < N_SLOTS; s++) exp_len[s] = 0;
  endtask

  initial begin
    int n, a, b, off, w, s;
    bus.i_key_rec = 0; bus.i_key_play = 0; bus.i_key_stop = 0;
    bus.i_slot_sel = 0; bus.i_loop = 0; bus.i_i2c_fin = 0;
    bus.i_rec_wr = 0; bus.i_play_off = 0;
    for (int i = 0; i < N_SLOTS; i++) exp_len[i] = 0;

    // ---- reset state
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("rst_state", 32'(bus.o_state), ST_INIT);
    chk("rst_pulses", pulses(), 0);
    chk("rst_play_en", 32'(bus.o_play_en), 0);
    chk("rst_we_n", 32'(bus.o_sram_we_n), 1);
    chk("rst_slot", 32'(bus.o_slot), 0);
    chk("rst_len", 32'(bus.o_len), 0);

    // ---- init handshake, keys ignored during I2C
    rst_n = 1'b0;
    cyc();
    chk("i2c_start_pulse", pulses(), P_I2C);
    chk("i2c_state", 32'(bus.o_state), ST_I2C);
    bus.i_key_rec = 1'b1; bus.i_key_play = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("i2c_wait_state", 32'(bus.o_state), ST_I2C);
      chk("i2c_wait_pulses", pulses(), 0);
      if (i == 4) begin bus.i_key_rec = 1'b0; bus.i_key_play = 1'b0; end
    end
    bus.i_i2c_fin = 1'b1;
    cyc();
    chk("i2c_to_idle", 32'(bus.o_state), ST_IDLE);
    chk("i2c_idle_pulses", pulses(), 0);

    // ---- record 100 words into slot 2
    start_rec(2);
    n = 0;
    rec_words(2, 100, n);
    exp_len[2] = n;
    stop_rec(2);

    // ---- fill slot 1: auto stop on the 256th write
    start_rec(1);
    bus.i_rec_wr = 1'b1;
    for (int k = 0; k < SLOT_SZ; k++) begin
      chk("full_addr", 32'(bus.o_sram_addr), SLOT_SZ + k);
      cyc();
      if (k < SLOT_SZ - 1) begin
        chk("full_state", 32'(bus.o_state), ST_RECD);
        chk("full_no_pulse", pulses(), 0);
      end
    end
    bus.i_rec_wr = 1'b0;
    exp_len[1] = SLOT_SZ;
    chk("full_stop_pulse", pulses(), P_RSTOP);
    chk("full_state_idle", 32'(bus.o_state), ST_IDLE);
    chk("full_len", 32'(bus.o_len), exp_len[1]);
    cyc();

    // ---- play slot 2 to end of take, no loop
    start_play(2);
    off = 0;
    while (off < exp_len[2]) begin
      bus.i_play_off = 9'(off);
      cyc();
      chk("play_state", 32'(bus.o_state), ST_PLAY);
      chk("play_addr", 32'(bus.o_sram_addr), 2 * SLOT_SZ + off);
      chk("play_no_pulse", pulses(), 0);
      off += $urandom_range(1, 7);
    end
    bus.i_play_off = 9'(exp_len[2]);
    cyc();
    chk("eot_stop_pulse", pulses(), P_DSTOP);
    chk("eot_play_en", 32'(bus.o_play_en), 0);
    chk("eot_state", 32'(bus.o_state), ST_IDLE);

    // ---- same with loop: stop+start together, stays in PLAY
    start_play(2);
    bus.i_loop = 1'b1;
    bus.i_play_off = 9'(exp_len[2]);
    cyc();
    chk("loop_pulses", pulses(), P_DS | P_DSTOP);
    chk("loop_state", 32'(bus.o_state), ST_PLAY);
    chk("loop_play_en", 32'(bus.o_play_en), 1);
    bus.i_play_off = '0;
    cyc();
    chk("loop_quiet", pulses(), 0);
    bus.i_key_stop = 1'b1;
    cyc();
    chk("loop_stop_pulse", pulses(), P_DSTOP);
    chk("loop_stop_state", 32'(bus.o_state), ST_IDLE);
    chk("loop_stop_play_en", 32'(bus.o_play_en), 0);
    bus.i_key_stop = 1'b0; bus.i_loop = 1'b0;
    cyc();

    // ---- play on an empty slot
    s = ($urandom_range(0, 1) == 0) ? 0 : 3;
    bus.i_slot_sel = 2'(s);
    bus.i_key_play = 1'b1;
    cyc();
    chk("empty_err", pulses(), P_ERR);
    chk("empty_state", 32'(bus.o_state), ST_IDLE);
    chk("empty_slot", 32'(bus.o_slot), s);
    bus.i_key_play = 1'b0;
    cyc();
    chk("empty_err_once", pulses(), 0);

    // ---- rec+stop edges together in RECD: stop wins
    start_rec(0);
    n = 0;
    w = $urandom_range(5, 30);
    rec_words(0, w, n);
    exp_len[0] = n;
    bus.i_key_rec = 1'b1; bus.i_key_stop = 1'b1;
    cyc();
    chk("prio_pulse", pulses(), P_RSTOP);
    chk("prio_state", 32'(bus.o_state), ST_IDLE);
    chk("prio_len", 32'(bus.o_len), exp_len[0]);
    bus.i_key_rec = 1'b0; bus.i_key_stop = 1'b0;
    cyc();

    // ---- record pause/resume in slot 3
    a = $urandom_range(3, 20);
    b = $urandom_range(3, 20);
    start_rec(3);
    n = 0;
    rec_words(3, a, n);
    bus.i_key_rec = 1'b1;
    cyc();
    chk("rpause_pulse", pulses(), P_RP);
    chk("rpause_state", 32'(bus.o_state), ST_RECP);
    chk("rpause_we_n", 32'(bus.o_sram_we_n), 1);
    bus.i_key_rec = 1'b0;
    bus.i_rec_wr = 1'b1;
    repeat (3) begin
      cyc();
      chk("rpause_addr_hold", 32'(bus.o_sram_addr), 3 * SLOT_SZ + n);
      chk("rpause_hold_state", 32'(bus.o_state), ST_RECP);
    end
    bus.i_rec_wr = 1'b0;
    bus.i_key_rec = 1'b1;
    cyc();
    chk("rresume_pulse", pulses(), P_RS);
    chk("rresume_state", 32'(bus.o_state), ST_RECD);
    bus.i_key_rec = 1'b0;
    rec_words(3, a + b, n);
    bus.i_key_play = 1'b1;
    cyc();
    chk("rec_play_err", pulses(), P_ERR);
    chk("rec_play_state", 32'(bus.o_state), ST_RECD);
    bus.i_key_play = 1'b0;
    exp_len[3] = n;
    stop_rec(3);

    // ---- play pause/resume in slot 3
    start_play(3);
    for (int k = 0; k < 3; k++) begin
      bus.i_play_off = 9'(k);
      cyc();
    end
    bus.i_key_play = 1'b1;
    cyc();
    chk("ppause_pulse", pulses(), P_DP);
    chk("ppause_state", 32'(bus.o_state), ST_PLAYP);
    chk("ppause_play_en", 32'(bus.o_play_en), 0);
    bus.i_key_play = 1'b0;
    bus.i_key_rec = 1'b1;
    cyc();
    chk("ppause_rec_err", pulses(), P_ERR);
    chk("ppause_rec_state", 32'(bus.o_state), ST_PLAYP);
    bus.i_key_rec = 1'b0;
    bus.i_key_play = 1'b1;
    cyc();
    chk("presume_pulse", pulses(), P_DS);
    chk("presume_play_en", 32'(bus.o_play_en), 1);
    chk("presume_state", 32'(bus.o_state), ST_PLAY);
    bus.i_key_play = 1'b0;
    bus.i_key_stop = 1'b1;
    cyc();
    chk("pstop_pulse", pulses(), P_DSTOP);
    chk("pstop_state", 32'(bus.o_state), ST_IDLE);
    bus.i_key_stop = 1'b0;
    cyc();

    // ---- reset mid-play: player enable drops without a clock edge
    start_play(1);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_play_en_async", 32'(bus.o_play_en), 0);
    chk("rst_play_state", 32'(bus.o_state), ST_INIT);
    boot();

    // ---- reset mid-record discards the take
    start_rec(2);
    n = 0;
    rec_words(2, 20, n);
    rst_n = 1'b1;
    #1;
    chk("rst_rec_state", 32'(bus.o_state), ST_INIT);
    chk("rst_rec_we_n", 32'(bus.o_sram_we_n), 1);
    chk("rst_rec_len", 32'(bus.o_len), 0);
    boot();
    bus.i_slot_sel = 2'd2;
    bus.i_key_play = 1'b1;
    cyc();
    chk("discarded_take_err", pulses(), P_ERR);
    chk("discarded_take_len", 32'(bus.o_len), exp_len[2]);
    bus.i_key_play = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
